// File: rtl/wb_stage.sv
// Writeback stage: WB control decode, register-file write port, one-cycle bypass, retire counter, halt/flush FSM.
// Latency: rf write is combinational and committed at the edge; bypass, counter and halt flags appear one cycle after.
// Backpressure: wb_en low stalls the stage, so nothing is written or counted until the instruction advances.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wb_valid,
    input  logic             wb_en,
    input  logic [3:0]       WBctrl,
    input  logic [31:0]      dmemload,
    input  logic [31:0]      aluout,
    input  logic [31:0]      npc,
    input  logic [15:0]      imm,
    input  logic [4:0]       dest,
    input  logic             flush_done,
    output logic             rf_WEN,
    output logic [4:0]       rf_wsel,
    output logic [31:0]      rf_wdat,
    output logic             fwd_valid,
    output logic [4:0]       fwd_sel,
    output logic [31:0]      fwd_dat,
    output logic             halt_req,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic       reg_write;
    logic [1:0] wb_sel;
    logic       halt_op;
    logic       retire;

    assign reg_write = WBctrl[0];
    assign wb_sel    = WBctrl[2:1];
    assign halt_op   = WBctrl[3];

    // Only a valid, advancing instruction retires, and only while the CPU is running.
    assign retire = wb_valid & wb_en & (state == RUN);

    // Write-back value select; the LUI case places the immediate in the upper half.
    always_comb begin
        rf_wdat = aluout;
        unique case (wb_sel)
            2'b00: rf_wdat = aluout;
            2'b01: rf_wdat = dmemload;
            2'b10: rf_wdat = npc;
            2'b11: rf_wdat = {imm, 16'h0000};
            default: rf_wdat = aluout;
        endcase
    end

    // r0 is hardwired zero, halt never writes, and the reset cycle never writes.
    assign rf_wsel = dest;
    assign rf_WEN  = retire & reg_write & ~halt_op & (dest != 5'd0) & ~RST;

    // Halt FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= RUN;
        else     state <= state_nxt;
    end

    // Halt FSM next state; flush_done only counts once FLUSH has actually been entered.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (retire && halt_op) state_nxt = FLUSH;
            FLUSH:   if (flush_done)        state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // Registered halt handshake flags, derived from the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            halt_req <= 1'b0;
            halt     <= 1'b0;
        end else begin
            halt_req <= (state_nxt == FLUSH);
            halt     <= (state_nxt == HALTED);
        end
    end

    // Bypass register mirrors the last write for exactly one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fwd_valid <= 1'b0;
            fwd_sel   <= 5'd0;
            fwd_dat   <= 32'd0;
        end else if (rf_WEN) begin
            fwd_valid <= 1'b1;
            fwd_sel   <= dest;
            fwd_dat   <= rf_wdat;
        end else begin
            fwd_valid <= 1'b0;
        end
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge CLK) begin
        if (RST)         retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage on the consumer side of the MEM/WB pipeline latch.
- Decodes the latched WB control word, selects the write-back value, and drives the register-file write port.
- Holds a one-cycle last-write bypass register for decode-stage read-after-write forwarding.
- Counts retired instructions and runs the halt/flush handshake with the memory controller.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous active-high reset
wb_valid  input  1  non-bubble instruction present in WB
wb_en  input  1  pipeline advance this cycle (latch ihit)
WBctrl  input  4  [0] RegWrite, [2:1] WBsel, [3] Halt
dmemload  input  32  load data from MEM/WB
aluout  input  32  ALU result from MEM/WB
npc  input  32  PC+4 from MEM/WB
imm  input  16  immediate from MEM/WB
dest  input  5  destination register
flush_done  input  1  dcache flush/writeback complete
rf_WEN  output  1  register-file write enable
rf_wsel  output  5  register-file write index
rf_wdat  output  32  register-file write data
fwd_valid  output  1  bypass register holds last write
fwd_sel  output  5  bypass register index
fwd_dat  output  32  bypass register data
halt_req  output  1  request dcache flush
halt  output  1  CPU halted, sticky
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset values (RST=1 at clock edge):
  - state=RUN
  - all registered outputs 0: fwd_*, halt_req, halt, retired
  - rf_WEN=0 during the reset cycle
- Retire condition: retire = wb_valid & wb_en & (state==RUN).
- WBsel decode:
  - 00 aluout
  - 01 dmemload
  - 10 npc
  - 11 {imm,16'h0000} (LUI)
- Write-back value is combinational:
  - rf_wdat = WBsel mux result.
  - rf_wsel = dest.
- rf_WEN = retire & RegWrite & ~Halt & (dest!=0). No write to r0 ever, regardless of RegWrite.
- Bypass register, next edge:
  - If rf_WEN: fwd_valid<=1, fwd_sel<=dest, fwd_dat<=rf_wdat.
  - Otherwise: fwd_valid<=0.
  - Valid for exactly one cycle per write.
- Retired counter:
  - Increments by 1 on every retire cycle, including halt and non-writing instructions.
  - Wraps modulo 2^CNT_W without saturating.
- wb_valid=1 & wb_en=0 (stall):
  - No write, no count, no state change.
  - Same instruction retires once, when wb_en rises.
- FSM (states RUN, FLUSH, HALTED):
  - RUN: retire & Halt -> FLUSH; halt_req<=1 from next cycle.
  - FLUSH: halt_req=1 held; flush_done=1 -> HALTED; halt_req<=0, halt<=1.
  - HALTED: terminal, halt=1 held until RST.
- Gating outside RUN: in FLUSH and HALTED, rf_WEN=0, counter frozen, fwd_valid<=0.
- flush_done while in RUN or HALTED is ignored.
- flush_done in the same cycle FLUSH is entered is ignored; it is sampled only while in FLUSH.
- RST mid-operation:
  - Any state returns to RUN next edge, counter=0, halt=0.
  - No write occurs in the reset cycle even if retire conditions hold.
- Latency:
  - Register-file write is same-cycle combinational, committed by the register file at the edge.
  - Bypass and counter are visible one cycle after retire.

Test Plan:
- ALU write: wb_valid=1, wb_en=1, WBctrl=4'b0001, dest=5, aluout=32'h1234 -> same cycle rf_WEN=1, rf_wsel=5, rf_wdat=32'h1234; next cycle fwd_valid=1, fwd_sel=5, fwd_dat=32'h1234, retired=1; following cycle fwd_valid=0.
- Select mux: WBsel=01 with dmemload=32'hDEADBEEF gives that; WBsel=10 with npc=32'h104 gives 32'h104; WBsel=11 with imm=16'hABCD gives 32'hABCD0000.
- r0 and stall: dest=0, RegWrite=1 -> rf_WEN=0, retired still increments. Then wb_valid=1, wb_en=0 for 3 cycles followed by wb_en=1 -> exactly one write, retired +1.
- Halt handshake:
  - Retire halt (WBctrl=4'b1000) -> halt_req=1 next cycle.
  - Hold flush_done=0 for 4 cycles -> halt_req stays 1, halt=0.
  - Pulse flush_done -> next cycle halt=1, halt_req=0.
  - Later retiring writes produce rf_WEN=0 and no count.
- Counter wrap: CNT_W=4, retire 17 instructions -> retired=1.
- Reset mid-FLUSH: assert RST during FLUSH with retire inputs active -> no write that cycle; next cycle state RUN, halt_req=0, retired=0, fwd_valid=0.
